// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } state_t;

  // Counter is sized for the widest legal operand so every instance shares one type.
  localparam int MAX_WIDTH = 32;
  localparam int CNT_W     = $clog2(MAX_WIDTH);

endpackage

// File: rtl/mult_add_row.sv
// One partial-product row: gates b with en and adds it to a, keeping the carry.
module mult_add_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH-1:0] w_pp;

  assign w_pp = b & {WIDTH{en}};
  assign sum  = {1'b0, a} + {1'b0, w_pp};

endmodule

// File: rtl/mult_seq.sv
// Radix-2 sequential multiplier: signed operands are reduced to magnitudes,
// multiplied unsigned one bit per clock, and the sign is restored at the end.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] m
);

  state_t               r_state;
  logic [WIDTH-1:0]     r_mag_x;
  logic [WIDTH-1:0]     r_mag_y;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_m;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH:0]       w_hi;

  // -2^(W-1) maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v,
                                              input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? ((~v) + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                    input logic               neg);
    return neg ? ((~v) + (2*WIDTH)'(1)) : v;
  endfunction

  mult_add_row #(.WIDTH(WIDTH)) u_row (
    .a   (r_acc[2*WIDTH-1:WIDTH]),
    .b   (r_mag_x),
    .en  (r_mag_y[0]),
    .sum (w_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mag_x <= '0;
      r_mag_y <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_mag_x <= mag_of(x, signed_mode);
            r_mag_y <= mag_of(y, signed_mode);
            r_neg   <= signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          // Carry of the row lands in the top bit; the LSB drops off the bottom.
          r_acc   <= {w_hi, r_acc[WIDTH-1:1]};
          r_mag_y <= r_mag_y >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_state <= SIGN;
          end
        end
        SIGN: begin
          r_m     <= apply_sign(r_acc, r_neg);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign m    = r_m;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: 8-bit vector table, handshake and reset
// sequences, plus a full 4-bit sweep against an integer reference.
module tb_mult_seq;

  logic clk;
  logic rst;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  x8, y8;
  logic [15:0] m8;

  logic        start4, sm4, busy4, done4;
  logic [3:0]  x4, y4;
  logic [7:0]  m4;

  int n_checks;
  int n_pass;

  typedef struct {
    logic        sm;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] m;
  } vec_t;

  vec_t vecs[10];

  mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .m(m8)
  );

  mult_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .x(x4), .y(y4), .busy(busy4), .done(done4), .m(m4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issues a start sampled at the next rising edge, then scrambles the inputs.
  task automatic start8_op(input logic sm, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start8 = 1'b1; sm8 = sm; x8 = a; y8 = b;
    @(posedge clk); #1;
    check("busy_after_start", busy8, 1);
    @(negedge clk);
    start8 = 1'b0; sm8 = ~sm; x8 = 8'hA5; y8 = 8'h5A;
  endtask

  // Edge count after the accepting edge until done is seen; -1 on timeout.
  task automatic wait_done8(output int edges);
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic wait_done4(output bit ok);
    ok = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int          edges;
    int          done_seen;
    bit          ok;
    logic [31:0] p;
    int          sa, sb;

    n_checks = 0;
    n_pass   = 0;
    start8 = 0; sm8 = 0; x8 = 0; y8 = 0;
    start4 = 0; sm4 = 0; x4 = 0; y4 = 0;

    vecs[0] = '{1'b0, 8'd13,  8'd11,  16'h008F};
    vecs[1] = '{1'b0, 8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{1'b0, 8'd0,   8'd200, 16'h0000};
    vecs[3] = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
    vecs[4] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    vecs[5] = '{1'b1, 8'h80,  8'h01,  16'hFF80};
    vecs[6] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
    vecs[7] = '{1'b1, 8'h7F,  8'h80,  16'hC080};
    vecs[8] = '{1'b0, 8'h80,  8'h80,  16'h4000};
    vecs[9] = '{1'b0, 8'hFD,  8'h05,  16'h04F1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_m",    m8,    0);
    check("reset_m4",   m4,    0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      start8_op(vecs[i].sm, vecs[i].x, vecs[i].y);
      wait_done8(edges);
      check($sformatf("vec%0d_latency", i), edges, 9);
      check($sformatf("vec%0d_m", i), m8, vecs[i].m);
      check($sformatf("vec%0d_busy_low", i), busy8, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_width", i), done8, 0);
      check($sformatf("vec%0d_m_hold", i), m8, vecs[i].m);
    end

    // Starts during CALC and on the SIGN edge are dropped; the one after is taken.
    for (int e = 0; e <= 10; e++) begin
      @(negedge clk);
      start8 = (e == 0 || e == 3 || e == 9 || e == 10);
      sm8    = (e == 3 || e == 9);
      x8     = (e == 0) ? 8'd13 : (e == 10) ? 8'd7 : 8'd99;
      y8     = (e == 0) ? 8'd11 : (e == 10) ? 8'd6 : 8'd77;
      @(posedge clk); #1;
      if (e == 8) check("hs_no_early_done", done8, 0);
      if (e == 9) begin
        check("hs_done", done8, 1);
        check("hs_m", m8, 16'h008F);
      end
      if (e == 10) begin
        check("hs_done_width", done8, 0);
        check("hs_next_accepted", busy8, 1);
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(edges);
    check("hs_next_latency", edges, 9);
    check("hs_next_m", m8, 16'h002A);

    // Abort mid-calculation after m holds a nonzero result.
    start8_op(1'b0, 8'd13, 8'd11);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_m",    m8,    0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    start8_op(1'b0, 8'd7, 8'd6);
    wait_done8(edges);
    check("after_abort_latency", edges, 9);
    check("after_abort_m", m8, 16'h002A);

    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          @(negedge clk);
          start4 = 1'b1; sm4 = s[0]; x4 = a[3:0]; y4 = b[3:0];
          @(posedge clk);
          @(negedge clk);
          start4 = 1'b0; x4 = ~x4; y4 = ~y4;
          wait_done4(ok);
          sa = (s == 1 && a >= 8) ? a - 16 : a;
          sb = (s == 1 && b >= 8) ? b - 16 : b;
          p  = sa * sb;
          if (!ok) check($sformatf("w4_timeout s%0d %0d*%0d", s, a, b), 0, 1);
          else     check($sformatf("w4 s%0d %0d*%0d", s, a, b), m4, {24'h0, p[7:0]});
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
